// File: rtl/mux81_arbiter_pkg.sv
// rtl/mux81_arbiter_pkg.sv - shared state encoding, sizes and one-hot helper for the 8:1 bit-lane arbiter
package mux81_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux81_arb_prio.sv
// rtl/mux81_arb_prio.sv - combinational rotating-priority search starting one past ptr
module mux81_arb_prio
    import mux81_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] w_cand;

    // k runs 1..8 so ptr itself is examined last; the 3-bit sum wraps mod 8
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = ptr + SEL_W'(k);
            if (!found && req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux81_arbiter.sv
// rtl/mux81_arbiter.sv - round-robin 8:1 bit-lane arbiter with registered grant and sampled data
// Define MUX81_ARB_TIMEOUT_EN to force rotation after HOLD_MAX grant cycles when others wait.
module mux81_arbiter
    import mux81_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   req,
    input  logic [7:0]   in_word,
    output logic [7:0]   gnt,
    output logic [2:0]   sel,
    output logic         out_bit,
    output logic         out_valid,
    output logic         busy
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
    logic               r_out_bit, r_out_valid;

    logic [NUM_REQ-1:0] w_prio_req;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic               w_limit;
    logic               w_keep;
    logic               w_new_grant;

    // While granting, the current owner is masked so the search only finds others;
    // r_ptr equals r_sel here, so the search starts right after the owner.
    assign w_prio_req = (r_state == ST_GRANT) ? (req & ~onehot(r_sel)) : req;

    mux81_arb_prio u_prio (
        .req   (w_prio_req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

`ifdef MUX81_ARB_TIMEOUT_EN
    logic [7:0] r_hold;

    assign w_limit = (r_hold >= HOLD_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= 8'd0;
        end else if (w_new_grant) begin
            r_hold <= 8'd0;
        end else if (r_state == ST_GRANT && r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
        end
    end
`else
    // Without the timeout the limit never fires; HOLD_LIM is tied in only to keep it referenced
    assign w_limit = 1'b0 & (|HOLD_LIM);
`endif

    assign w_keep = req[r_sel] && !(w_limit && w_found);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_new_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_new_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_keep) begin
                    if (w_found) begin
                        w_new_grant = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        if (w_new_grant) begin
            w_gnt_nxt = onehot(w_idx);
            w_sel_nxt = w_idx;
            w_ptr_nxt = w_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_sel       <= '0;
            r_ptr       <= SEL_W'(NUM_REQ - 1);
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_ptr       <= w_ptr_nxt;
            r_out_valid <= |r_gnt;
            if (r_state == ST_GRANT) begin
                r_out_bit <= in_word[r_sel];
            end
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_bit   = r_out_bit;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mux81_arbiter.sv
// tb/tb_mux81_arbiter.sv - directed bench for mux81_arbiter with hand-computed expectations
module tb_mux81_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] in_word;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       out_bit;
    logic       out_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mux81_arbiter #(.HOLD_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_word   (in_word),
        .gnt       (gnt),
        .sel       (sel),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] tmo_seq [7];
        tmo_seq = '{8'h01, 8'h01, 8'h01, 8'h04, 8'h04, 8'h04, 8'h01};

        rst     = 1'b1;
        req     = 8'h00;
        in_word = 8'h00;
        tick();
        tick();
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_sel", sel, 3'd0);
        chk("rst_out_bit", out_bit, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Single request: grant after one edge, data after two
        req     = 8'h01;
        in_word = 8'h01;
        tick();
        chk("lat_gnt", gnt, 8'h01);
        chk("lat_sel", sel, 3'd0);
        chk("lat_busy", busy, 1'b1);
        chk("lat_valid_early", out_valid, 1'b0);
        in_word = 8'h00;
        tick();
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_bit", out_bit, 1'b0);
        in_word = 8'h01;
        tick();
        chk("lat_bit_follow", out_bit, 1'b1);
        req = 8'h00;
        tick();
        chk("idle_gnt", gnt, 8'h00);
        chk("idle_busy", busy, 1'b0);
        chk("idle_sel_hold", sel, 3'd0);
        chk("idle_valid_tail", out_valid, 1'b1);
        tick();
        chk("idle_valid_drop", out_valid, 1'b0);

        // All requesting; owner 0 drops after 4 cycles -> seamless handover
        do_reset();
        req     = 8'hFF;
        in_word = 8'h02;
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef MUX81_ARB_TIMEOUT_EN
            if (i < 3) chk("ff_hold0", gnt, 8'h01);
            else       chk("ff_hold0", gnt, 8'h02);
`else
            chk("ff_hold0", gnt, 8'h01);
`endif
        end
`ifndef MUX81_ARB_TIMEOUT_EN
        req = 8'hFE;
        tick();
        chk("ff_handover", gnt, 8'h02);
        chk("ff_handover_sel", sel, 3'd1);
        chk("ff_handover_busy", busy, 1'b1);
        chk("ff_handover_bit", out_bit, 1'b0);
        tick();
        chk("ff_new_bit", out_bit, 1'b1);
        req = 8'hFC;
        tick();
        chk("ff_next", gnt, 8'h04);
        // Owner 2 drops while 0 and 3 are up: search resumes after 2
        req = 8'h09;
        tick();
        chk("drop_rise", gnt, 8'h08);
        chk("drop_rise_sel", sel, 3'd3);
        rst = 1'b1;
        tick();
        chk("midrst_gnt", gnt, 8'h00);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_sel", sel, 3'd0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        req = 8'h88;
        tick();
        chk("post_rst_gnt", gnt, 8'h08);
        chk("post_rst_sel", sel, 3'd3);
`endif

        // Wrap from pointer 7
        do_reset();
        req = 8'h81;
        tick();
        chk("wrap_gnt", gnt, 8'h01);
        req = 8'h80;
        tick();
        chk("wrap_next", gnt, 8'h80);
        chk("wrap_next_sel", sel, 3'd7);
        req = 8'h00;
        tick();
        chk("wrap_idle_gnt", gnt, 8'h00);
        chk("wrap_idle_sel", sel, 3'd7);
        req = 8'h81;
        tick();
        chk("wrap_again", gnt, 8'h01);

        // Lone requester 5 keeps the lane even past the hold limit
        do_reset();
        req = 8'h20;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lone5", gnt, 8'h20);
        end

        // Two requesters 0 and 2 held
        do_reset();
        req = 8'h05;
        for (int i = 0; i < 7; i++) begin
            tick();
`ifdef MUX81_ARB_TIMEOUT_EN
            chk("tmo_seq", gnt, tmo_seq[i]);
`else
            chk("notmo_hold", gnt, 8'h01);
`endif
        end
        req = 8'h00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux81_arbiter.md
MUX81_ARBITER -- requirements
Module: mux81_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16: maximum consecutive grant cycles per requester; legal range 1..255.
REQ-002 The clock SHALL be clk, input, 1 bit; all state updates on its rising edge.
REQ-003 The reset SHALL be rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 req, input, 8 bits: req[i] high means requester i wants the shared bit lane.
REQ-005 in_word, input, 8 bits: in_word[i] is requester i's data bit.
REQ-006 gnt, output, 8 bits, registered: one-hot grant, or all-zero when idle.
REQ-007 sel, output, 3 bits, registered: index of the granted requester; drives the shared 8:1 select.
REQ-008 out_bit, output, 1 bit, registered: sampled in_word[sel].
REQ-009 out_valid, output, 1 bit, registered: out_bit carries granted data.
REQ-010 busy, output, 1 bit: high when state is GRANT.

Function
REQ-011 The FSM SHALL have two states, IDLE and GRANT.
- IDLE, any req high -> GRANT.
- GRANT, current req dropped and no other req -> IDLE.
REQ-012 Arbitration SHALL be round-robin from a 3-bit last-grant pointer.
- Search order: pointer+1, pointer+2, ... wrapping mod 8.
- The first requester found high wins.
REQ-013 Latency: req sampled high at edge N SHALL give gnt/sel at edge N+1 and out_valid/out_bit at edge N+2.
REQ-014 In GRANT, out_bit SHALL load in_word[sel] every cycle; out_valid SHALL be gnt-delayed-by-one, ORed across bits.
REQ-015 Grant SHALL persist while req[sel] stays high, except under REQ-021.
REQ-016 When req[sel] drops, the next edge SHALL hand over with no idle bubble.
- Another req high: grant the next requester in round-robin order after sel.
- No other req: gnt=0 and state=IDLE.
REQ-017 The pointer SHALL update to the new sel on every new grant.
REQ-018 gnt SHALL never have more than one bit set; sel SHALL equal the index of the set bit.
REQ-019 When IDLE, gnt SHALL be 0 and sel SHALL hold its last value.
REQ-020 Simultaneous req drop and rise in the same cycle SHALL be resolved using the req vector sampled at that edge only.

Reset
REQ-022 rst SHALL take priority over all other inputs at the edge it is sampled.
REQ-023 After reset the outputs and state SHALL be:
- state=IDLE, gnt=0, sel=0, out_bit=0, out_valid=0, busy=0.
- pointer=7, so requester 0 has first priority.
- hold counter=0.
REQ-024 rst asserted mid-grant SHALL drop gnt and out_valid at that edge; no partial state SHALL survive.

Configuration
REQ-021 Macro MUX81_ARB_TIMEOUT_EN SHALL enable the hold-limit behaviour.
- Defined: an 8-bit hold counter counts grant cycles.
- After HOLD_MAX cycles with another req pending, the next edge SHALL force rotation as in REQ-016, even with req[sel] high.
- If no other req is pending, the counter saturates and the grant holds.
- The counter clears on each new grant.
- Undefined: no counter exists, HOLD_MAX is ignored, and grant holds until req[sel] drops.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE=0, GRANT=1), the requester count 8, and the select width 3.
REQ-026 The rotating priority search SHALL be a sub-module, mux81_arb_prio.
- Inputs: req[7:0], ptr[2:0].
- Outputs: found, idx[2:0].
- Purely combinational.
- The top SHALL instantiate it once.

Verification
REQ-027 A directed bench SHALL cover:
- Reset, then req=8'h01 at cycle 1 -> gnt=8'h01, sel=0 at cycle 2; out_valid=1 with out_bit=in_word[0] at cycle 3.
- req=8'hFF held, timeout macro undefined, requester 0 drops after 4 cycles -> grants go 0,1 with no bubble.
- Timeout macro defined, HOLD_MAX=3, req=8'h05 held -> grant sequence 0,0,0,2,2,2,0 and gnt never zero.
- Single requester 5 held 20 cycles, HOLD_MAX=3, macro defined -> gnt stays 8'h20 throughout.
- rst pulsed while gnt=8'h08 -> next cycle gnt=0, out_valid=0; then req=8'h88 -> gnt=8'h08 (pointer reset to 7).
- Pointer=7 and req=8'h81 -> grant goes to 0 (wrap); next handover goes to 7.
